// File: rtl/extclk_pkg.sv
// Shared definitions for the external clock generator: phase encoding,
// per-phase clock decode table and the default oscillator settle time.
package extclk_pkg;

  // Default number of CLK edges the oscillator needs before it is trusted.
  localparam int unsigned OSC_STABLE_CYCLES_DEF = 8;

  // One M-cycle is four CLK periods, one per phase.
  typedef enum logic [1:0] {
    PH_ADR   = 2'd0,
    PH_DATA  = 2'd1,
    PH_INC   = 2'd2,
    PH_LATCH = 2'd3
  } phase_t;

  // Bit positions of the individual clocks inside a decoded clock vector.
  localparam int CK_ADR   = 4;
  localparam int CK_DATA  = 3;
  localparam int CK_INC   = 2;
  localparam int CK_MAIN  = 1;
  localparam int CK_LATCH = 0;

  typedef logic [4:0] clk_vec_t;

  // Decode table indexed by phase, fields {adr, data, inc, main, latch}.
  localparam clk_vec_t [3:0] PHASE_DECODE = {
    5'b01001,  // PH_LATCH
    5'b01110,  // PH_INC
    5'b10100,  // PH_DATA
    5'b10010   // PH_ADR
  };

  function automatic clk_vec_t decode_phase(input phase_t ph);
    return PHASE_DECODE[ph];
  endfunction

endpackage

// File: rtl/extclk_reset_sync.sv
// Reset synchronizer: asserts immediately with rst_in, releases on the
// second CLK edge after rst_in falls so downstream flops leave reset cleanly.
module extclk_reset_sync (
  input  logic CLK,
  input  logic rst_in,
  output logic rst_out
);

  logic meta;

  // Two-flop chain, asynchronously set, shifting in the deasserted level.
  always_ff @(posedge CLK or posedge rst_in) begin
    if (rst_in) begin
      meta    <= 1'b1;
      rst_out <= 1'b1;
    end else begin
      meta    <= 1'b0;
      rst_out <= meta;
    end
  end

endmodule

// File: rtl/external_clk.sv
// External clock generator: brings the core out of reset once the oscillator
// has settled, then produces the four-phase M-cycle clocks as flop outputs.
// Build option: EXTCLK_OSC_WAIT_EN enables the OSC_STABLE_CYCLES settle
// counter; without it OSC_STABLE follows reset release by one edge.
module external_clk
  import extclk_pkg::*;
#(
  parameter int unsigned OSC_STABLE_CYCLES = OSC_STABLE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RESET,
  output logic ADR_CLK_P,
  output logic ADR_CLK_N,
  output logic DATA_CLK_P,
  output logic DATA_CLK_N,
  output logic INC_CLK_P,
  output logic INC_CLK_N,
  output logic MAIN_CLK_P,
  output logic MAIN_CLK_N,
  output logic LATCH_CLK,
  output logic OSC_ENA,
  output logic OSC_STABLE,
  output logic CLK_ENA,
  output logic ASYNC_RESET,
  output logic SYNC_RESET
);

  logic       async_reset;
  logic       osc_stable;
  logic       clk_ena;
  logic       clk_ena_nxt;
  logic       sync_reset;
  phase_t     phase;
  phase_t     phase_nxt;
  clk_vec_t   clk_dec;
  clk_vec_t   clk_p;
  logic [4:1] clk_n;

  extclk_reset_sync u_reset_sync (
    .CLK     (CLK),
    .rst_in  (RESET),
    .rst_out (async_reset)
  );

`ifdef EXTCLK_OSC_WAIT_EN
  localparam logic [7:0] STABLE_LAST = 8'(OSC_STABLE_CYCLES - 1);

  logic [7:0] stable_cnt;

  // Count settle edges after reset release; OSC_STABLE sets on the last one.
  always_ff @(posedge CLK or posedge async_reset) begin
    if (async_reset) begin
      stable_cnt <= '0;
      osc_stable <= 1'b0;
    end else if (!osc_stable) begin
      if (stable_cnt == STABLE_LAST) begin
        osc_stable <= 1'b1;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end
`else
  // No settle wait: oscillator is trusted on the first edge out of reset.
  // The settle-length parameter has no effect in this build.
  always_ff @(posedge CLK or posedge async_reset) begin
    if (async_reset) begin
      osc_stable <= 1'b0;
    end else if (OSC_STABLE_CYCLES != 0) begin
      osc_stable <= 1'b1;
    end
  end
`endif

  // Enable follows stable by one edge and is sticky until reset; the phase
  // counter only runs once enabled.
  assign clk_ena_nxt = clk_ena | osc_stable;
  assign phase_nxt   = clk_ena ? phase_t'(phase + 2'd1) : PH_ADR;
  assign clk_dec     = decode_phase(phase_nxt);

  // Clock-enable, phase counter and M-cycle-aligned reset release.
  always_ff @(posedge CLK or posedge async_reset) begin
    if (async_reset) begin
      clk_ena    <= 1'b0;
      phase      <= PH_ADR;
      sync_reset <= 1'b1;
    end else begin
      clk_ena <= clk_ena_nxt;
      phase   <= phase_nxt;
      if (clk_ena && (phase == PH_LATCH)) begin
        sync_reset <= 1'b0;
      end
    end
  end

  // Registered clock outputs, decoded from the phase being loaded this edge
  // so every output changes on the same edge as the phase register.
  always_ff @(posedge CLK or posedge async_reset) begin
    if (async_reset) begin
      clk_p <= '0;
      clk_n <= '1;
    end else if (clk_ena_nxt) begin
      clk_p <= clk_dec;
      clk_n <= ~clk_dec[4:1];
    end else begin
      clk_p <= '0;
      clk_n <= '1;
    end
  end

  assign ADR_CLK_P   = clk_p[CK_ADR];
  assign ADR_CLK_N   = clk_n[CK_ADR];
  assign DATA_CLK_P  = clk_p[CK_DATA];
  assign DATA_CLK_N  = clk_n[CK_DATA];
  assign INC_CLK_P   = clk_p[CK_INC];
  assign INC_CLK_N   = clk_n[CK_INC];
  assign MAIN_CLK_P  = clk_p[CK_MAIN];
  assign MAIN_CLK_N  = clk_n[CK_MAIN];
  assign LATCH_CLK   = clk_p[CK_LATCH];
  assign OSC_ENA     = ~async_reset;
  assign OSC_STABLE  = osc_stable;
  assign CLK_ENA     = clk_ena;
  assign ASYNC_RESET = async_reset;
  assign SYNC_RESET  = sync_reset;

endmodule

// File: tb/tb_external_clk.sv
// Directed bench for external_clk: reset values, bring-up timing, free-run
// phase patterns, mid-operation reset and a sub-period reset pulse. A second
// instance with OSC_STABLE_CYCLES=1 shares the clock and reset.
module tb_external_clk;

`ifdef EXTCLK_OSC_WAIT_EN
  localparam int S = 9;
`else
  localparam int S = 2;
`endif

  logic CLK = 1'b0;
  logic RESET;

  logic ADR_CLK_P, ADR_CLK_N, DATA_CLK_P, DATA_CLK_N;
  logic INC_CLK_P, INC_CLK_N, MAIN_CLK_P, MAIN_CLK_N;
  logic LATCH_CLK, OSC_ENA, OSC_STABLE, CLK_ENA, ASYNC_RESET, SYNC_RESET;

  logic adr_p_1, adr_n_1, data_p_1, data_n_1, inc_p_1, inc_n_1, main_p_1, main_n_1;
  logic latch_1, osc_ena_1, osc_stable_1, clk_ena_1, async_reset_1, sync_reset_1;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected patterns, phase 0 in the leftmost bit.
  logic [3:0] adr_pat   = 4'b1100;
  logic [3:0] data_pat  = 4'b0011;
  logic [3:0] inc_pat   = 4'b0110;
  logic [3:0] main_pat  = 4'b1010;
  logic [3:0] latch_pat = 4'b0001;

  external_clk dut (
    .CLK(CLK), .RESET(RESET),
    .ADR_CLK_P(ADR_CLK_P), .ADR_CLK_N(ADR_CLK_N),
    .DATA_CLK_P(DATA_CLK_P), .DATA_CLK_N(DATA_CLK_N),
    .INC_CLK_P(INC_CLK_P), .INC_CLK_N(INC_CLK_N),
    .MAIN_CLK_P(MAIN_CLK_P), .MAIN_CLK_N(MAIN_CLK_N),
    .LATCH_CLK(LATCH_CLK), .OSC_ENA(OSC_ENA), .OSC_STABLE(OSC_STABLE),
    .CLK_ENA(CLK_ENA), .ASYNC_RESET(ASYNC_RESET), .SYNC_RESET(SYNC_RESET)
  );

  external_clk #(.OSC_STABLE_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET(RESET),
    .ADR_CLK_P(adr_p_1), .ADR_CLK_N(adr_n_1),
    .DATA_CLK_P(data_p_1), .DATA_CLK_N(data_n_1),
    .INC_CLK_P(inc_p_1), .INC_CLK_N(inc_n_1),
    .MAIN_CLK_P(main_p_1), .MAIN_CLK_N(main_n_1),
    .LATCH_CLK(latch_1), .OSC_ENA(osc_ena_1), .OSC_STABLE(osc_stable_1),
    .CLK_ENA(clk_ena_1), .ASYNC_RESET(async_reset_1), .SYNC_RESET(sync_reset_1)
  );

  always #10 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] req);
    n_chk++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s edge=%0d observed=%02h expected=%02h", tag, idx, obs, req);
  endtask

  task automatic chk_reset_state(input string tag, input int idx);
    // {ASYNC_RESET, OSC_ENA, OSC_STABLE, CLK_ENA, SYNC_RESET}
    chk({tag, "_ctrl"}, idx, {3'b0, ASYNC_RESET, OSC_ENA, OSC_STABLE, CLK_ENA, SYNC_RESET}, 8'b0001_0001);
    chk({tag, "_p"}, idx, {3'b0, ADR_CLK_P, DATA_CLK_P, INC_CLK_P, MAIN_CLK_P, LATCH_CLK}, 8'h00);
    chk({tag, "_n"}, idx, {4'b0, ADR_CLK_N, DATA_CLK_N, INC_CLK_N, MAIN_CLK_N}, 8'h0F);
    chk({tag, "_osc1"}, idx, {4'b0, async_reset_1, osc_stable_1, clk_ena_1, sync_reset_1}, 8'h09);
  endtask

  // RESET must already be low before the first edge waited here (edge k).
  task automatic bringup(input int n_edges);
    logic       e_async, e_stable, e_ena, e_sync;
    logic [4:0] e_p;
    int         ph;
    for (int j = 0; j < n_edges; j++) begin
      step();
      e_async  = (j < 1);
      e_stable = (j >= S);
      e_ena    = (j >= S + 1);
      e_sync   = (j < S + 5);
      chk("bring_ctrl", j, {3'b0, ASYNC_RESET, OSC_ENA, OSC_STABLE, CLK_ENA, SYNC_RESET},
          {3'b0, e_async, !e_async, e_stable, e_ena, e_sync});
      e_p = 5'b00000;
      if (e_ena) begin
        ph  = (j - (S + 1)) % 4;
        e_p = {adr_pat[3-ph], data_pat[3-ph], inc_pat[3-ph], main_pat[3-ph], latch_pat[3-ph]};
      end
      chk("clk_p", j, {3'b0, ADR_CLK_P, DATA_CLK_P, INC_CLK_P, MAIN_CLK_P, LATCH_CLK}, {3'b0, e_p});
      chk("clk_n", j, {4'b0, ADR_CLK_N, DATA_CLK_N, INC_CLK_N, MAIN_CLK_N}, {4'b0, ~e_p[4:1]});
      chk("osc1", j, {6'b0, osc_stable_1, clk_ena_1}, {6'b0, (j >= 2), (j >= 3)});
    end
  endtask

  initial begin
    RESET = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk_reset_state("rst_imm", -1);
    repeat (8) step();
    chk_reset_state("rst_held", 8);

    // First release on the falling clock edge, then bring-up plus 64 free-run edges.
    #9 RESET = 1'b0;
    bringup(S + 65);

    // Advance to phase 2 and reset in the middle of the M-cycle.
    repeat (3) step();
    chk("phase2", 0, {3'b0, ADR_CLK_P, DATA_CLK_P, INC_CLK_P, MAIN_CLK_P, LATCH_CLK}, 8'b0000_1110);
    RESET = 1'b1;
    #1;
    chk_reset_state("mid_rst", 0);
    step();
    chk_reset_state("mid_rst_held", 1);
    #9 RESET = 1'b0;
    bringup(S + 12);

    // Reset pulse entirely between two rising edges.
    #4 RESET = 1'b1;
    #1;
    chk_reset_state("pulse", 0);
    #9 RESET = 1'b0;
    bringup(S + 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/external_clk.md
EXTERNAL_CLK -- requirements
Module: external_clk

Interface
REQ-001 Parameter OSC_STABLE_CYCLES, default 8: CLK edges from ASYNC_RESET release to OSC_STABLE assertion; legal range 1..255.
REQ-002 CLK  input  1  single system clock; all flops on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 ADR_CLK_P / ADR_CLK_N  output  1 each  address-phase clock, true/complement.
REQ-005 DATA_CLK_P / DATA_CLK_N  output  1 each  data-phase clock, true/complement.
REQ-006 INC_CLK_P / INC_CLK_N  output  1 each  incrementer clock, true/complement.
REQ-007 MAIN_CLK_P / MAIN_CLK_N  output  1 each  main core clock, true/complement.
REQ-008 LATCH_CLK  output  1  end-of-M-cycle latch strobe.
REQ-009 OSC_ENA, OSC_STABLE, CLK_ENA  output  1 each  oscillator enable, oscillator stable, core clock enable.
REQ-010 ASYNC_RESET, SYNC_RESET  output  1 each  core asynchronous reset, core M-cycle-aligned reset.

Function
REQ-011 A 2-bit phase register SHALL hold 0 while CLK_ENA=0 and SHALL advance 0,1,2,3,0 on every CLK edge while CLK_ENA=1; one M-cycle = 4 CLK periods.
REQ-012 Phase decode (phase 0/1/2/3): ADR_CLK_P 1,1,0,0; DATA_CLK_P 0,0,1,1; INC_CLK_P 0,1,1,0; MAIN_CLK_P 1,0,1,0; LATCH_CLK 0,0,0,1.
REQ-013 Every clock output SHALL be a flop output, updated on the same edge as the phase register, so no output glitches.
REQ-014 Each _N output SHALL be the exact complement of its _P output in every cycle, including reset.
REQ-015 While CLK_ENA=0, all _P outputs and LATCH_CLK SHALL be 0 and all _N outputs 1.
REQ-016 On the edge where CLK_ENA rises, the outputs SHALL take the phase-0 decode.
REQ-017 ASYNC_RESET SHALL assert combinationally with RESET and SHALL deassert through a 2-flop synchronizer on the second CLK edge after RESET falls (edge k+1 if RESET falls before edge k).
REQ-018 OSC_ENA SHALL equal ~ASYNC_RESET.
REQ-019 The stabilization counter SHALL count CLK edges while ASYNC_RESET=0 and OSC_STABLE=0; OSC_STABLE SHALL set on the OSC_STABLE_CYCLES-th edge (k+9 at default) and SHALL stay set until reset.
REQ-020 CLK_ENA SHALL set on the edge after OSC_STABLE sets (k+10) and SHALL stay set until reset.
REQ-021 SYNC_RESET SHALL be 1 from reset until the edge where the phase first wraps 3->0 (k+14), then 0.
REQ-022 A RESET asserted mid-operation SHALL force all outputs to their reset values immediately, whatever the phase or counter state.
REQ-023 A RESET pulse shorter than one CLK period SHALL still complete the full restart sequence.

Reset
REQ-024 Reset values: ASYNC_RESET=1, SYNC_RESET=1, OSC_ENA=0, OSC_STABLE=0, CLK_ENA=0, phase=0, counter=0, _P=0, _N=1, LATCH_CLK=0.

Configuration
REQ-025 With EXTCLK_OSC_WAIT_EN defined, OSC_STABLE timing follows REQ-019.
REQ-026 Without EXTCLK_OSC_WAIT_EN, the counter SHALL be omitted and OSC_STABLE SHALL set on the first edge after ASYNC_RESET deasserts (k+2), with CLK_ENA at k+3 and SYNC_RESET release at k+7.

Structure
REQ-027 Package extclk_pkg SHALL hold the phase constants (PH_ADR=0 .. PH_LATCH=3), the per-phase decode table and the OSC_STABLE_CYCLES default.
REQ-028 The reset synchronizer SHALL be one sub-module, extclk_reset_sync, instantiated once.

Verification
REQ-029 RESET high 8 edges, then low before edge k -> ASYNC_RESET falls at k+1, OSC_STABLE rises at k+9, CLK_ENA at k+10, SYNC_RESET falls at k+14.
REQ-030 Free run for 64 edges after CLK_ENA -> ADR_CLK_P pattern 1100, INC_CLK_P 0110, MAIN_CLK_P 1010, LATCH_CLK 0001 repeating; each _N equals ~_P on every edge.
REQ-031 RESET asserted at phase 2 -> same-timestep ASYNC_RESET=1, CLK_ENA=0, all _P=0, all _N=1; release -> full sequence repeats from REQ-029.
REQ-032 RESET pulse 10 ns wide between edges -> ASYNC_RESET pulses, OSC_STABLE restarts from 0 and rises 9 edges later.
REQ-033 Build without EXTCLK_OSC_WAIT_EN -> OSC_STABLE rises at k+2 and SYNC_RESET falls at k+7.
REQ-034 OSC_STABLE_CYCLES=1 -> OSC_STABLE rises at k+2, CLK_ENA at k+3.
